// File: rtl/bcd_serial_add_seq.sv
// Multi-digit BCD add sequencer: drives an external single-digit BCD stage LSD first (optional BCD_SEQ_EARLY_ABORT_EN).
// Latency: start sampled at T0, digits captured T1..T_DIGITS, done pulses for one cycle after T_DIGITS.
// Backpressure: none; start is only honoured in IDLE, ignored (not queued) in RUN/DONE.
module bcd_serial_add_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  error,
  output logic [3:0]            dig_a,
  output logic [3:0]            dig_b,
  output logic                  dig_cin,
  input  logic [3:0]            dig_sum,
  input  logic                  dig_carry,
  input  logic                  dig_error
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [IDXW-1:0]         idx;
  logic [DIGITS-1:0][3:0]  a_q, b_q, result_q;
  logic                    carry_q, cout_q, error_q;
  logic [3:0]              cur_a, cur_b;
  logic                    last, abort;

  // Digit select as an explicit mux so non-power-of-two DIGITS never indexes past the array
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDXW'(i)) begin
        cur_a = a_q[i];
        cur_b = b_q[i];
      end
    end
  end

  assign last = (idx == IDXW'(DIGITS - 1));

`ifdef BCD_SEQ_EARLY_ABORT_EN
  assign abort = dig_error;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dig_a     = 4'd0;
    dig_b     = 4'd0;
    dig_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        dig_a   = cur_a;
        dig_b   = cur_b;
        dig_cin = carry_q;
        if (last || abort) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_q      <= op_a;
        b_q      <= op_b;
        carry_q  <= cin;
        idx      <= '0;
        result_q <= '0;
        error_q  <= 1'b0;
        cout_q   <= 1'b0;
      end else if (state == RUN) begin
        // An aborted digit is left at zero, as are all digits above it
        if (!abort) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDXW'(i)) result_q[i] <= dig_sum;
          end
        end
        carry_q <= dig_carry;
        error_q <= error_q | dig_error;
        if (!last) idx <= idx + IDXW'(1);
        if (abort) begin
          cout_q <= 1'b0;
        end else if (last) begin
          cout_q <= dig_carry;
        end
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign error  = error_q;

endmodule

// File: tb/tb_bcd_serial_add_seq.sv
// Directed bench for bcd_serial_add_seq: DIGITS=4 and DIGITS=1 instances, each with a reference digit stage.
module tb_bcd_serial_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  int          nvec = 0;
  int          nerr = 0;

  // DIGITS=4 instance
  logic        start, cin, busy, done, cout, error;
  logic [15:0] op_a, op_b, result;
  logic [3:0]  dig_a, dig_b, dig_sum;
  logic        dig_cin, dig_carry, dig_error;

  // DIGITS=1 instance
  logic        start1, cin1, busy1, done1, cout1, error1;
  logic [3:0]  op_a1, op_b1, result1;
  logic [3:0]  dig_a1, dig_b1, dig_sum1;
  logic        dig_cin1, dig_carry1, dig_error1;

  always #5 clk = ~clk;

  // Reference stage: invalid input digits yield sum 0, carry 0, error 1
  function automatic logic [5:0] bcd_ref(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] s;
    if (a > 4'd9 || b > 4'd9) return 6'b10_0000;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    if (s > 5'd9) return {1'b0, 1'b1, 4'(s - 5'd10)};
    return {1'b0, 1'b0, s[3:0]};
  endfunction

  assign {dig_error, dig_carry, dig_sum}    = bcd_ref(dig_a, dig_b, dig_cin);
  assign {dig_error1, dig_carry1, dig_sum1} = bcd_ref(dig_a1, dig_b1, dig_cin1);

  bcd_serial_add_seq #(.DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .error(error),
    .dig_a(dig_a), .dig_b(dig_b), .dig_cin(dig_cin),
    .dig_sum(dig_sum), .dig_carry(dig_carry), .dig_error(dig_error)
  );

  bcd_serial_add_seq #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .error(error1),
    .dig_a(dig_a1), .dig_b(dig_b1), .dig_cin(dig_cin1),
    .dig_sum(dig_sum1), .dig_carry(dig_carry1), .dig_error(dig_error1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] exp_res, input logic exp_cout,
                         input logic exp_err, input int exp_edges);
    int n;
    int nb;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".dig_a0"}, dig_a, a[3:0]);
    check({tag, ".dig_b0"}, dig_b, b[3:0]);
    check({tag, ".dig_cin0"}, dig_cin, c);
    n = 0;
    nb = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
    check({tag, ".done_edges"}, n, exp_edges);
    check({tag, ".busy_cycles"}, nb, exp_edges);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".cout"}, cout, exp_cout);
    check({tag, ".error"}, error, exp_err);
    check({tag, ".busy_in_done"}, busy, 1'b0);
    tick();
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".result_held"}, result, exp_res);
  endtask

  initial begin
    int n;
    int seen;
    int abort_edges;
`ifdef BCD_SEQ_EARLY_ABORT_EN
    abort_edges = 2;
`else
    abort_edges = 4;
`endif
    rst_n = 1'b0;
    start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
    #12;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", result, 16'h0000);
    check("rst.cout", cout, 1'b0);
    check("rst.error", error, 1'b0);
    check("rst.dig_a", dig_a, 4'h0);
    rst_n = 1'b1;
    tick();

    run_add("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 4);
    run_add("add9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    run_add("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4);
    run_add("bad_digit", 16'h00A1, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b1, abort_edges);
    run_add("after_err", 16'h0450, 16'h0550, 1'b1, 16'h1001, 1'b0, 1'b0, 4);

    // start during RUN and DONE must be ignored
    op_a = 16'h1234; op_b = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op_a = 16'h9999; op_b = 16'h9999; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    check("ign.done_edges", n, 2);
    op_a = 16'h8888; op_b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign.result", result, 16'h6912);
    check("ign.busy_after_done", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    check("ign.no_second_run", seen, 0);
    check("ign.result_held", result, 16'h6912);

    // Reset low across edge T2 aborts the run
    op_a = 16'h1234; op_b = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort.partial", result, 16'h0002);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.result", result, 16'h0000);
    check("abort.dig_a", dig_a, 4'h0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    check("abort.no_done", seen, 0);
    run_add("post_rst", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4);

    // DIGITS=1 instance
    op_a1 = 4'h7; op_b1 = 4'h5; cin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("d1.busy", busy1, 1'b1);
    check("d1.dig_a", dig_a1, 4'h7);
    tick();
    check("d1.done", done1, 1'b1);
    check("d1.result", result1, 4'h2);
    check("d1.cout", cout1, 1'b1);
    check("d1.error", error1, 1'b0);
    tick();
    check("d1.done_pulse", done1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
